// File: rtl/switch_route_allocator.sv
// Route-reservation allocator: per-output round-robin arbitration with output locking
// until the owning input relieves it. All outputs come straight from flops.
//
// state  | meaning
// FREE   | output unowned, arbitrates candidates each cycle
// LOCKED | output owned by r_sel, waits for relieve from that owner
module switch_route_allocator #(
    parameter int PORTS         = 5,
    parameter int REQUEST_WIDTH = 3
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic [PORTS-1:0]                 i_req_valid,
    input  logic [PORTS*REQUEST_WIDTH-1:0]   i_req_dest,
    input  logic [PORTS-1:0]                 i_relieve,
    output logic [PORTS-1:0]                 o_grant,
    output logic [PORTS-1:0]                 o_in_reserved,
    output logic [PORTS-1:0]                 o_out_busy,
    output logic [PORTS*REQUEST_WIDTH-1:0]   o_out_sel
);

    localparam int RW = REQUEST_WIDTH;

    typedef enum logic {
        FREE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t          r_state      [PORTS];
    state_t          w_state_next [PORTS];
    logic [RW-1:0]   r_sel        [PORTS];
    logic [RW-1:0]   w_sel_next   [PORTS];
    logic [RW-1:0]   r_ptr        [PORTS];
    logic [RW-1:0]   w_ptr_next   [PORTS];
    logic [PORTS-1:0] r_grant;
    logic [PORTS-1:0] r_in_res;
    logic [PORTS-1:0] w_grant_next;
    logic [PORTS-1:0] w_clr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int o = 0; o < PORTS; o++) begin
                r_state[o] <= FREE;
                r_sel[o]   <= '0;
                r_ptr[o]   <= '0;
            end
            r_grant  <= '0;
            r_in_res <= '0;
        end else begin
            for (int o = 0; o < PORTS; o++) begin
                r_state[o] <= w_state_next[o];
                r_sel[o]   <= w_sel_next[o];
                r_ptr[o]   <= w_ptr_next[o];
            end
            r_grant  <= w_grant_next;
            r_in_res <= (r_in_res & ~w_clr) | w_grant_next;
        end
    end

    always_comb begin
        logic [PORTS-1:0] cand;
        logic             found;
        w_grant_next = '0;
        w_clr        = '0;
        cand         = '0;
        found        = 1'b0;
        for (int o = 0; o < PORTS; o++) begin
            w_state_next[o] = r_state[o];
            w_sel_next[o]   = r_sel[o];
            w_ptr_next[o]   = r_ptr[o];
        end
        for (int o = 0; o < PORTS; o++) begin
            // Reserved inputs are excluded, so a held request is never granted twice.
            for (int i = 0; i < PORTS; i++) begin
                cand[i] = i_req_valid[i] && !r_in_res[i]
                          && (i_req_dest[i*RW +: RW] == RW'(o));
            end
            found = 1'b0;
            case (r_state[o])
                FREE: begin
                    // Two passes give the cyclic search starting at the pointer.
                    for (int i = 0; i < PORTS; i++) begin
                        if (!found && cand[i] && (RW'(i) >= r_ptr[o])) begin
                            found           = 1'b1;
                            w_state_next[o] = LOCKED;
                            w_sel_next[o]   = RW'(i);
                            w_ptr_next[o]   = (i == PORTS-1) ? '0 : RW'(i+1);
                            w_grant_next[i] = 1'b1;
                        end
                    end
                    for (int i = 0; i < PORTS; i++) begin
                        if (!found && cand[i] && (RW'(i) < r_ptr[o])) begin
                            found           = 1'b1;
                            w_state_next[o] = LOCKED;
                            w_sel_next[o]   = RW'(i);
                            w_ptr_next[o]   = (i == PORTS-1) ? '0 : RW'(i+1);
                            w_grant_next[i] = 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    for (int i = 0; i < PORTS; i++) begin
                        if ((r_sel[o] == RW'(i)) && i_relieve[i]) begin
                            w_state_next[o] = FREE;
                            w_sel_next[o]   = '0;
                            w_clr[i]        = 1'b1;
                        end
                    end
                end
                default: w_state_next[o] = FREE;
            endcase
        end
    end

    always_comb begin
        o_out_busy = '0;
        o_out_sel  = '0;
        for (int o = 0; o < PORTS; o++) begin
            o_out_busy[o]           = (r_state[o] == LOCKED);
            o_out_sel[o*RW +: RW]   = r_sel[o];
        end
    end

    assign o_grant       = r_grant;
    assign o_in_reserved = r_in_res;

endmodule
